// File: rtl/mc_dp_pkg.sv
// Shared types and constants for the multi-cycle RV32I datapath.
package mc_dp_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned PC_INC  = 4;
    localparam int unsigned X0_IDX  = 0;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4
    } state_e;

    // Decoder controls captured in DECODE and held for the rest of the instruction.
    typedef struct packed {
        logic reg_write;
        logic mem2reg;
        logic alu_src;
        logic mem_write;
        logic mem_read;
    } ctrl_t;

endpackage

// File: rtl/alu_32.sv
// 32-bit ALU driven by the ALU-control code from the external ALU-control block.
module alu_32 (
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [3:0]  alu_control,
    output logic [31:0] alu_result
);

    always_comb begin
        alu_result = '0;
        case (alu_control)
            4'b0000: alu_result = a_in & b_in;
            4'b0001: alu_result = a_in | b_in;
            4'b0010: alu_result = a_in + b_in;
            4'b0011: alu_result = a_in ^ b_in;
            4'b0100: alu_result = a_in << b_in[4:0];
            4'b0101: alu_result = a_in >> b_in[4:0];
            4'b0110: alu_result = a_in - b_in;
            4'b0111: alu_result = {31'b0, $signed(a_in) < $signed(b_in)};
            4'b1000: alu_result = 32'($signed(a_in) >>> b_in[4:0]);
            4'b1001: alu_result = {31'b0, a_in < b_in};
            4'b1100: alu_result = ~(a_in | b_in);
            default: alu_result = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen.sv
// RV32I immediate generator, selected by the instruction opcode.
module imm_gen (
    input  logic [31:0] inst_code,
    output logic [31:0] imm_out
);

    always_comb begin
        imm_out = '0;
        case (inst_code[6:0])
            7'b0000011, 7'b0010011, 7'b1100111:
                imm_out = {{20{inst_code[31]}}, inst_code[31:20]};
            7'b0100011:
                imm_out = {{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
            7'b1100011:
                imm_out = {{19{inst_code[31]}}, inst_code[31], inst_code[7],
                           inst_code[30:25], inst_code[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm_out = {inst_code[31:12], 12'b0};
            7'b1101111:
                imm_out = {{11{inst_code[31]}}, inst_code[31], inst_code[19:12],
                           inst_code[20], inst_code[30:21], 1'b0};
            default: imm_out = '0;
        endcase
    end

endmodule

// File: rtl/mc_reg_file.sv
// 32-entry register file: two combinational read ports, one write port, x0 hardwired to zero.
module mc_reg_file
    import mc_dp_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata2
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != AW'(X0_IDX))) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1 = (raddr1 == AW'(X0_IDX)) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == AW'(X0_IDX)) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/multicycle_data_path.sv
// Multi-cycle RV32I datapath sharing one instruction/data memory port over a req/ack handshake.
module multicycle_data_path
    import mc_dp_pkg::*;
#(
    parameter int unsigned PC_W       = 8,
    parameter int unsigned INS_W      = 32,
    parameter int unsigned RF_ADDRESS = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned ALU_CC_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write,
    input  logic                  mem2reg,
    input  logic                  alu_src,
    input  logic                  mem_write,
    input  logic                  mem_read,
    input  logic [ALU_CC_W-1:0]   alu_cc,
    output logic [6:0]            opcode,
    output logic [6:0]            funct7,
    output logic [2:0]            funct3,
    output logic [DATA_W-1:0]     alu_result,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  instr_done,
    output logic [STATE_W-1:0]    fsm_state
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INS_W-1:0]    ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [DATA_W-1:0]   alu_out_q, alu_out_d, mdr_q, mdr_d;
    ctrl_t               ctl_q, ctl_d;
    logic [ALU_CC_W-1:0] alu_cc_q, alu_cc_d;
    logic                instr_done_q, instr_done_d;

    logic [DATA_W-1:0]   rf_rd1_c, rf_rd2_c, rf_wdata_c, imm_c, alu_b_c, alu_y_c;
    logic                rf_we_c, mem_req_c, in_mem_c;

    assign rf_we_c    = (state_q == S_WB);
    assign rf_wdata_c = ctl_q.mem2reg ? mdr_q : alu_out_q;
    assign alu_b_c    = ctl_q.alu_src ? imm_q : b_q;

    mc_reg_file #(.DATA_W(DATA_W), .AW(RF_ADDRESS)) u_rf (
        .clk    (clk),
        .rst_n  (reset),
        .we     (rf_we_c),
        .waddr  (ir_q[11:7]),
        .wdata  (rf_wdata_c),
        .raddr1 (ir_q[19:15]),
        .rdata1 (rf_rd1_c),
        .raddr2 (ir_q[24:20]),
        .rdata2 (rf_rd2_c)
    );

    imm_gen u_imm (
        .inst_code (ir_q),
        .imm_out   (imm_c)
    );

    alu_32 u_alu (
        .a_in        (a_q),
        .b_in        (alu_b_c),
        .alu_control (alu_cc_q),
        .alu_result  (alu_y_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            ir_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            imm_q        <= '0;
            alu_out_q    <= '0;
            mdr_q        <= '0;
            ctl_q        <= '0;
            alu_cc_q     <= '0;
            instr_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            a_q          <= a_d;
            b_q          <= b_d;
            imm_q        <= imm_d;
            alu_out_q    <= alu_out_d;
            mdr_q        <= mdr_d;
            ctl_q        <= ctl_d;
            alu_cc_q     <= alu_cc_d;
            instr_done_q <= instr_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        ctl_d     = ctl_q;
        alu_cc_d  = alu_cc_q;

        case (state_q)
            S_FETCH: begin
                if (mem_ack) begin
                    ir_d    = INS_W'(mem_rdata);
                    pc_d    = pc_q + PC_W'(PC_INC);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d             = rf_rd1_c;
                b_d             = rf_rd2_c;
                imm_d           = imm_c;
                ctl_d.reg_write = reg_write;
                ctl_d.mem2reg   = mem2reg;
                ctl_d.alu_src   = alu_src;
                ctl_d.mem_write = mem_write;
                ctl_d.mem_read  = mem_read;
                alu_cc_d        = alu_cc;
                state_d         = S_EXECUTE;
            end
            S_EXECUTE: begin
                alu_out_d = alu_y_c;
                if (ctl_q.mem_read || ctl_q.mem_write) begin
                    state_d = S_MEM;
                end else if (ctl_q.reg_write) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                // A latched store takes priority, so MDR only captures on a pure load.
                if (mem_ack) begin
                    if (!ctl_q.mem_write) begin
                        mdr_d = mem_rdata;
                    end
                    state_d = ctl_q.reg_write ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        instr_done_d = (state_d == S_FETCH) && (state_q != S_FETCH);
    end

    // Request is a decode of the state flop, gated by reset so it drops the moment reset asserts.
    assign in_mem_c   = (state_q == S_MEM);
    assign mem_req_c  = reset && ((state_q == S_FETCH) || in_mem_c);

    assign mem_req    = mem_req_c;
    assign mem_we     = in_mem_c && ctl_q.mem_write;
    assign mem_addr   = in_mem_c ? alu_out_q[DM_ADDRESS-1:0] : DM_ADDRESS'(pc_q);
    assign mem_wdata  = in_mem_c ? b_q : '0;
    assign opcode     = ir_q[6:0];
    assign funct7     = ir_q[31:25];
    assign funct3     = ir_q[14:12];
    assign alu_result = alu_out_q;
    assign instr_done = instr_done_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_multicycle_data_path.sv
// Directed bench for multicycle_data_path: small program in a word memory, stepped on falling edges.
module tb_multicycle_data_path;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write, mem2reg, alu_src, mem_write, mem_read;
    logic [3:0]  alu_cc;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic        mem_req, mem_we, mem_ack;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        instr_done;
    logic [2:0]  fsm_state;

    logic [31:0] mem [128];

    int n_pass = 0;
    int n_chk  = 0;

    logic        got_mem, req_in_wb, cap_we;
    logic [31:0] cap_addr, cap_wdata, cap_alu;

    always #5 clk = ~clk;

    multicycle_data_path dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .mem2reg    (mem2reg),
        .alu_src    (alu_src),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .alu_cc     (alu_cc),
        .opcode     (opcode),
        .funct7     (funct7),
        .funct3     (funct3),
        .alu_result (alu_result),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .instr_done (instr_done),
        .fsm_state  (fsm_state)
    );

    assign mem_rdata = mem[mem_addr[8:2]];

    // Stand-in for the main decoder + ALU control (only the add-style ops used here).
    always_comb begin
        {reg_write, mem2reg, alu_src, mem_write, mem_read} = 5'b0;
        alu_cc = 4'b0010;
        case (opcode)
            7'b0010011: begin reg_write = 1'b1; alu_src = 1'b1; end
            7'b0110011: reg_write = 1'b1;
            7'b0000011: begin reg_write = 1'b1; mem2reg = 1'b1; alu_src = 1'b1; mem_read = 1'b1; end
            7'b0100011: begin alu_src = 1'b1; mem_write = 1'b1; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Commits a store that the coming rising edge will accept, then moves to the next falling edge.
    task automatic step();
        if (mem_req && mem_we && mem_ack) mem[mem_addr[8:2]] = mem_wdata;
        @(negedge clk);
    endtask

    task automatic run_instr(input string tag, input int exp_lat);
        int n = 0;
        got_mem   = 1'b0;
        req_in_wb = 1'b0;
        do begin
            step();
            n++;
            if (fsm_state == 3'd3 && !got_mem) begin
                got_mem   = 1'b1;
                cap_addr  = 32'(mem_addr);
                cap_wdata = mem_wdata;
                cap_we    = mem_we;
                cap_alu   = alu_result;
            end
            if (fsm_state == 3'd4 && mem_req) req_in_wb = 1'b1;
        end while (!instr_done && n < 20);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    initial begin
        reset   = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0] = 32'h00500093;   // addi x1,x0,5
        mem[1] = 32'h00102423;   // sw   x1,8(x0)
        mem[3] = 32'h00802103;   // lw   x2,8(x0)
        mem[4] = 32'h08202023;   // sw   x2,128(x0)
        mem[5] = 32'h00700013;   // addi x0,x0,7
        mem[6] = 32'h000001B3;   // add  x3,x0,x0
        mem[7] = 32'h08302223;   // sw   x3,132(x0)
        mem[63] = 32'h00900293;  // addi x5,x0,9

        step();
        step();
        check("reset_ctrl_outs", 32'({mem_req, mem_we, instr_done, fsm_state, opcode, funct3}), 32'h0);
        check("reset_mem_addr", 32'(mem_addr), 32'h0);
        check("reset_alu_result", alu_result, 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);

        reset = 1'b1;
        #1;
        check("fetch0_req", 32'(mem_req), 32'h1);
        check("fetch0_addr", 32'(mem_addr), 32'h0);

        run_instr("addi_x1", 4);
        check("addi_alu", alu_result, 32'd5);
        check("addi_next_pc", 32'(mem_addr), 32'd4);

        // Store with memory stalling three cycles in MEM.
        step();
        check("done_single_pulse", 32'(instr_done), 32'h0);
        check("sw_decode_state", 32'(fsm_state), 32'd1);
        mem_ack = 1'b0;
        step();
        check("sw_exec_state", 32'(fsm_state), 32'd2);
        step();
        for (int k = 0; k < 4; k++) begin
            check("sw_stall_state", 32'(fsm_state), 32'd3);
            check("sw_stall_req", 32'(mem_req), 32'h1);
            check("sw_stall_we", 32'(mem_we), 32'h1);
            check("sw_stall_addr", 32'(mem_addr), 32'd8);
            check("sw_stall_wdata", mem_wdata, 32'd5);
            check("sw_stall_no_done", 32'(instr_done), 32'h0);
            if (k == 3) mem_ack = 1'b1;
            step();
        end
        check("sw_done_after_ack", 32'(instr_done), 32'h1);
        check("sw_next_pc", 32'(mem_addr), 32'd8);
        check("sw_mem_written", mem[2], 32'd5);

        run_instr("nop_word8", 3);
        check("nop_next_pc", 32'(mem_addr), 32'd12);

        run_instr("lw_x2", 5);
        check("lw_mem_addr", cap_addr, 32'd8);
        check("lw_alu_in_mem", cap_alu, 32'd8);
        check("lw_mem_we", 32'(cap_we), 32'h0);
        check("lw_req_drop_in_wb", 32'(req_in_wb), 32'h0);

        run_instr("sw_x2", 4);
        check("sw_x2_addr", cap_addr, 32'd128);
        check("sw_x2_wdata", cap_wdata, 32'd5);
        check("sw_x2_mem", mem[32], 32'd5);

        run_instr("addi_x0", 4);
        run_instr("add_x3", 4);
        check("add_x3_alu", alu_result, 32'h0);
        run_instr("sw_x3", 4);
        check("sw_x3_addr", cap_addr, 32'd132);
        check("sw_x3_wdata", cap_wdata, 32'h0);

        for (int i = 8; i < 63; i++) run_instr("nop_fill", 3);
        check("fetch_252_addr", 32'(mem_addr), 32'd252);
        check("fetch_252_req", 32'(mem_req), 32'h1);

        run_instr("addi_x5", 4);
        check("addi_x5_alu", alu_result, 32'd9);
        check("pc_wrap_addr", 32'(mem_addr), 32'h0);

        // Reset in the middle of a stalled fetch.
        mem_ack = 1'b0;
        step();
        step();
        check("fetch_wait_req", 32'(mem_req), 32'h1);
        check("fetch_wait_state", 32'(fsm_state), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("abort_req", 32'(mem_req), 32'h0);
        check("abort_alu", alu_result, 32'h0);
        check("abort_opcode", 32'(opcode), 32'h0);
        mem[0] = 32'h08502623;   // sw x5,140(x0)
        step();
        reset   = 1'b1;
        mem_ack = 1'b1;
        #1;
        check("restart_addr", 32'(mem_addr), 32'h0);
        run_instr("sw_x5_after_reset", 4);
        check("sw_x5_addr", cap_addr, 32'd140);
        check("sw_x5_wdata_cleared", cap_wdata, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
